// File: rtl/regfile_sb_pkg.sv
// regfile_pkg
// Shared definitions for the regfile_sb register file:
//   - default DATA_W / ADDR_W / NUM_RD values
//   - clear-engine FSM state type
//   - port_slice(): pulls one port's field out of a packed multi-port bus
// No ports (package).
package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_RD  = 2;

    // Upper bounds used to size the generic slice helper.
    localparam int MAX_NUM_RD  = 4;
    localparam int MAX_SLICE_W = 32;
    localparam int MAX_BUS_W   = MAX_NUM_RD * MAX_SLICE_W;
    localparam int IDX_W       = $clog2(MAX_BUS_W);

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    // Returns bits [port*width +: width] of bus, zero-extended to MAX_SLICE_W.
    // Callers zero-extend their bus to MAX_BUS_W and truncate the result.
    function automatic logic [MAX_SLICE_W-1:0] port_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   port,
        input int                   width
    );
        logic [MAX_SLICE_W-1:0] slice;
        logic [IDX_W-1:0]       idx;
        slice = '0;
        for (int b = 0; b < MAX_SLICE_W; b++) begin
            if (b < width) begin
                idx      = IDX_W'(port * width + b);
                slice[b] = bus[idx];
            end
        end
        return slice;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if
// Bus bundle between the decode stage (master) and the register file (slave).
//   write port : rg_wrt_en, rg_wrt_addr, rg_wrt_data
//   read ports : rg_rd_addr (packed, NUM_RD fields) -> rg_rd_data, rg_rd_busy
//   scoreboard : sb_set_en, sb_set_addr
//   soft clear : clr_req -> clr_busy
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);

    logic                       rg_wrt_en;
    logic [ADDR_W-1:0]          rg_wrt_addr;
    logic [DATA_W-1:0]          rg_wrt_data;
    logic [NUM_RD*ADDR_W-1:0]   rg_rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rg_rd_data;
    logic [NUM_RD-1:0]          rg_rd_busy;
    logic                       sb_set_en;
    logic [ADDR_W-1:0]          sb_set_addr;
    logic                       clr_req;
    logic                       clr_busy;

    modport master (
        output rg_wrt_en, rg_wrt_addr, rg_wrt_data, rg_rd_addr,
               sb_set_en, sb_set_addr, clr_req,
        input  rg_rd_data, rg_rd_busy, clr_busy
    );

    modport slave (
        input  rg_wrt_en, rg_wrt_addr, rg_wrt_data, rg_rd_addr,
               sb_set_en, sb_set_addr, clr_req,
        output rg_rd_data, rg_rd_busy, clr_busy
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard
// One pending-write (busy) bit per register.
//   clk, reset          : clock, async active-high reset (all bits cleared)
//   set_en, set_addr    : mark a register pending
//   wr_en, wr_addr      : a write retires the pending mark for its register
//   clr_en, clr_ptr     : soft-clear sweep; zeroes busy[clr_ptr] and blocks set/write
//   busy                : current busy vector
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_ptr,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // The set is applied after the write-clear so a same-address set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_ptr] = 1'b0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (set_en) begin
                busy_d[set_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised register file with write-to-read bypass, pending-write
// scoreboard and a sequential soft-clear engine.
//   clk    : clock, all state updates on the rising edge
//   reset  : async active-high reset; zeroes array and scoreboard, FSM to idle
//   bus    : regfile_sb_if.slave (write port, NUM_RD read ports with busy
//            flags, scoreboard set port, clear request / clear busy)
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic              clearing;
    logic              wr_fire;

    assign clearing     = (state_q == CLR_RUN);
    assign wr_fire      = bus.rg_wrt_en && !clearing;
    assign bus.clr_busy = clearing;

    // Clear engine: one entry per cycle, leaves after the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLR_IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                end
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    // The sweep owns the array while running; writes are simply dropped.
    always_comb begin
        mem_d = mem_q;
        if (clearing) begin
            mem_d[ptr_q] = '0;
        end else if (bus.rg_wrt_en &&
                     !((ZERO_REG != 0) && (bus.rg_wrt_addr == '0))) begin
            mem_d[bus.rg_wrt_addr] = bus.rg_wrt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (bus.sb_set_en),
        .set_addr (bus.sb_set_addr),
        .wr_en    (bus.rg_wrt_en),
        .wr_addr  (bus.rg_wrt_addr),
        .clr_en   (clearing),
        .clr_ptr  (ptr_q),
        .busy     (busy_vec)
    );

    // Read ports: zero register beats bypass, bypass beats the array.
    // A forwarded write hides the stored busy bit unless a same-cycle set
    // targets the same register.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              fwd;

        assign ra       = ADDR_W'(port_slice(MAX_BUS_W'(bus.rg_rd_addr), k, ADDR_W));
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign fwd      = (BYPASS != 0) && wr_fire && (bus.rg_wrt_addr == ra);

        assign bus.rg_rd_data[k*DATA_W +: DATA_W] =
            zero_hit ? '0 : (fwd ? bus.rg_wrt_data : mem_q[ra]);
        assign bus.rg_rd_busy[k] =
            zero_hit ? 1'b0
                     : (fwd ? (bus.sb_set_en && (bus.sb_set_addr == ra))
                            : busy_vec[ra]);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Instance A: default configuration (32x32, 2 read ports, zero register,
// bypass), checked every cycle against a behavioural model plus directed
// literal expectations. Instance B: 16x16, 3 read ports, no zero register,
// no bypass, checked with directed literal expectations.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3)) bus_b ();

    regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_sb #(
        .DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model of instance A: register contents, pending flags and
    // the index of the entry the sweep will wipe next (-1 when not sweeping).
    logic [31:0] m_mem  [32];
    logic        m_busy [32];
    int          sweep_idx = -1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  <= 32'h0;
                m_busy[i] <= 1'b0;
            end
            sweep_idx <= -1;
        end else if (sweep_idx >= 0) begin
            m_mem[sweep_idx]  <= 32'h0;
            m_busy[sweep_idx] <= 1'b0;
            sweep_idx <= (sweep_idx == 31) ? -1 : sweep_idx + 1;
        end else begin
            if (bus_a.rg_wrt_en && bus_a.rg_wrt_addr != 5'd0) begin
                m_mem[bus_a.rg_wrt_addr]  <= bus_a.rg_wrt_data;
                m_busy[bus_a.rg_wrt_addr] <= 1'b0;
            end
            if (bus_a.sb_set_en && bus_a.sb_set_addr != 5'd0) begin
                m_busy[bus_a.sb_set_addr] <= 1'b1;
            end
            if (bus_a.clr_req) begin
                sweep_idx <= 0;
            end
        end
    end

    // Compare process: every falling edge, all instance-A outputs.
    always @(negedge clk) begin
        logic [4:0]  a;
        logic [31:0] exp_d;
        logic        exp_b;
        for (int k = 0; k < 2; k++) begin
            a = bus_a.rg_rd_addr[k*5 +: 5];
            if (a == 5'd0) begin
                exp_d = 32'h0;
                exp_b = 1'b0;
            end else if (sweep_idx < 0 && bus_a.rg_wrt_en && bus_a.rg_wrt_addr == a) begin
                exp_d = bus_a.rg_wrt_data;
                exp_b = bus_a.sb_set_en && (bus_a.sb_set_addr == a);
            end else begin
                exp_d = m_mem[a];
                exp_b = m_busy[a];
            end
            check_output($sformatf("A_rd_data_p%0d", k),
                         64'(bus_a.rg_rd_data[k*32 +: 32]), 64'(exp_d));
            check_output($sformatf("A_rd_busy_p%0d", k),
                         64'(bus_a.rg_rd_busy[k]), 64'(exp_b));
        end
        check_output("A_clr_busy", 64'(bus_a.clr_busy), 64'(sweep_idx >= 0));
    end

    task automatic apply_stimulus(input logic we, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic [4:0] r0,
                                  input logic [4:0] r1, input logic se,
                                  input logic [4:0] sa, input logic cr);
        @(posedge clk);
        #1;
        bus_a.rg_wrt_en   = we;
        bus_a.rg_wrt_addr = wa;
        bus_a.rg_wrt_data = wd;
        bus_a.rg_rd_addr  = {r1, r0};
        bus_a.sb_set_en   = se;
        bus_a.sb_set_addr = sa;
        bus_a.clr_req     = cr;
    endtask

    task automatic apply_stimulus_b(input logic we, input logic [3:0] wa,
                                    input logic [15:0] wd, input logic [3:0] r0,
                                    input logic [3:0] r1, input logic [3:0] r2,
                                    input logic cr);
        @(posedge clk);
        #1;
        bus_b.rg_wrt_en   = we;
        bus_b.rg_wrt_addr = wa;
        bus_b.rg_wrt_data = wd;
        bus_b.rg_rd_addr  = {r2, r1, r0};
        bus_b.clr_req     = cr;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cnt;
        logic [4:0]  wa;
        logic [4:0]  sa;
        logic [4:0]  r0;

        bus_a.rg_wrt_en = 1'b0; bus_a.rg_wrt_addr = '0; bus_a.rg_wrt_data = '0;
        bus_a.rg_rd_addr = '0;  bus_a.sb_set_en = 1'b0; bus_a.sb_set_addr = '0;
        bus_a.clr_req = 1'b0;
        bus_b.rg_wrt_en = 1'b0; bus_b.rg_wrt_addr = '0; bus_b.rg_wrt_data = '0;
        bus_b.rg_rd_addr = '0;  bus_b.sb_set_en = 1'b0; bus_b.sb_set_addr = '0;
        bus_b.clr_req = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_rd_data", 64'(bus_a.rg_rd_data), 64'h0);
        check_output("reset_rd_busy", 64'(bus_a.rg_rd_busy), 64'h0);
        check_output("reset_clr_busy", 64'(bus_a.clr_busy), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic write/read and hardwired zero register
        apply_stimulus(1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 5'd0, 0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd0, 5'd5, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x5_data", 64'(bus_a.rg_rd_data[63:32]), 64'hDEADBEEF);
        check_output("x5_busy", 64'(bus_a.rg_rd_busy[1]), 64'h0);
        apply_stimulus(1, 5'd0, 32'h1234, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x0_bypass", 64'(bus_a.rg_rd_data[31:0]), 64'h0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x0_data", 64'(bus_a.rg_rd_data[31:0]), 64'h0);

        // Bypass: both ports see the write before the edge
        apply_stimulus(1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 0, 5'd0, 0);
        @(negedge clk);
        check_output("bypass_p0", 64'(bus_a.rg_rd_data[31:0]), 64'hA5A5A5A5);
        check_output("bypass_p1", 64'(bus_a.rg_rd_data[63:32]), 64'hA5A5A5A5);

        // Scoreboard
        apply_stimulus(0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 5'd0, 32'h0, 5'd9, 5'd0, 0, 5'd0, 0);
            @(negedge clk);
            check_output("x9_set_busy", 64'(bus_a.rg_rd_busy[0]), 64'h1);
        end
        apply_stimulus(1, 5'd9, 32'h77, 5'd9, 5'd0, 0, 5'd0, 0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd9, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x9_wr_busy", 64'(bus_a.rg_rd_busy[0]), 64'h0);
        check_output("x9_wr_data", 64'(bus_a.rg_rd_data[31:0]), 64'h77);
        apply_stimulus(1, 5'd9, 32'h99, 5'd9, 5'd0, 1, 5'd9, 0);
        @(negedge clk);
        check_output("x9_setwr_fwd_busy", 64'(bus_a.rg_rd_busy[0]), 64'h1);
        apply_stimulus(0, 5'd0, 32'h0, 5'd9, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x9_setwr_data", 64'(bus_a.rg_rd_data[31:0]), 64'h99);
        check_output("x9_setwr_busy", 64'(bus_a.rg_rd_busy[0]), 64'h1);

        // Soft clear over an array filled with each entry's index
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1, 5'(i), 32'(i), 5'd0, 5'd0, 0, 5'd0, 0);
        end
        apply_stimulus(0, 5'd0, 32'h0, 5'd3, 5'd4, 0, 5'd0, 1);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            apply_stimulus(cnt == 5, 5'd3, 32'hFFFF, 5'd3, 5'(cnt), 0, 5'd0, cnt == 10);
            @(negedge clk);
            if (bus_a.clr_busy) cnt++;
            else break;
        end
        check_output("clear_len_A", 64'(cnt), 64'd32);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, 5'd0, 32'h0, 5'(2*i), 5'(2*i+1), 0, 5'd0, 0);
            @(negedge clk);
            check_output("post_clear_p0", 64'(bus_a.rg_rd_data[31:0]), 64'h0);
            check_output("post_clear_p1", 64'(bus_a.rg_rd_data[63:32]), 64'h0);
        end

        // Reset in the middle of a clear
        apply_stimulus(1, 5'd20, 32'hAAAA, 5'd0, 5'd0, 0, 5'd0, 0);
        apply_stimulus(1, 5'd31, 32'hBBBB, 5'd0, 5'd0, 0, 5'd0, 0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd31, 0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd20, 5'd31, 0, 5'd0, 1);
        repeat (10) apply_stimulus(0, 5'd0, 32'h0, 5'd20, 5'd31, 0, 5'd0, 0);
        @(negedge clk);
        check_output("midclr_x20", 64'(bus_a.rg_rd_data[31:0]), 64'hAAAA);
        check_output("midclr_x31", 64'(bus_a.rg_rd_data[63:32]), 64'hBBBB);
        check_output("midclr_x31_busy", 64'(bus_a.rg_rd_busy[1]), 64'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_output("rst_x20", 64'(bus_a.rg_rd_data[31:0]), 64'h0);
        check_output("rst_x31", 64'(bus_a.rg_rd_data[63:32]), 64'h0);
        check_output("rst_busy", 64'(bus_a.rg_rd_busy), 64'h0);
        check_output("rst_clr_busy", 64'(bus_a.clr_busy), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        apply_stimulus(1, 5'd4, 32'h55, 5'd0, 5'd0, 0, 5'd0, 0);
        apply_stimulus(0, 5'd0, 32'h0, 5'd4, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check_output("x4_after_rst", 64'(bus_a.rg_rd_data[31:0]), 64'h55);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            wa = 5'($urandom);
            sa = ($urandom % 3 == 0) ? wa : 5'($urandom);
            r0 = ($urandom % 3 == 0) ? wa : 5'($urandom);
            apply_stimulus(1'($urandom), wa, $urandom, r0, 5'($urandom),
                           ($urandom % 4 == 0), sa, ($urandom_range(0, 199) == 0));
        end
        apply_stimulus(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);

        // Instance B: 3 ports, 16-bit, 16 deep, no zero register, no bypass
        apply_stimulus_b(1, 4'd0, 16'h1111, 4'd0, 4'd0, 4'd0, 0);
        apply_stimulus_b(1, 4'd1, 16'h2222, 4'd0, 4'd0, 4'd0, 0);
        apply_stimulus_b(1, 4'd2, 16'h3333, 4'd0, 4'd0, 4'd0, 0);
        apply_stimulus_b(0, 4'd0, 16'h0, 4'd2, 4'd0, 4'd1, 0);
        @(negedge clk);
        check_output("B_p0", 64'(bus_b.rg_rd_data[15:0]), 64'h3333);
        check_output("B_p1", 64'(bus_b.rg_rd_data[31:16]), 64'h1111);
        check_output("B_p2", 64'(bus_b.rg_rd_data[47:32]), 64'h2222);
        check_output("B_busy", 64'(bus_b.rg_rd_busy), 64'h0);
        apply_stimulus_b(1, 4'd1, 16'hBEEF, 4'd1, 4'd1, 4'd1, 0);
        @(negedge clk);
        check_output("B_nobypass", 64'(bus_b.rg_rd_data[15:0]), 64'h2222);
        apply_stimulus_b(0, 4'd0, 16'h0, 4'd1, 4'd0, 4'd1, 0);
        @(negedge clk);
        check_output("B_after_wr_p0", 64'(bus_b.rg_rd_data[15:0]), 64'hBEEF);
        check_output("B_after_wr_p2", 64'(bus_b.rg_rd_data[47:32]), 64'hBEEF);
        apply_stimulus_b(0, 4'd0, 16'h0, 4'd0, 4'd1, 4'd2, 1);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            apply_stimulus_b(0, 4'd0, 16'h0, 4'd0, 4'd1, 4'd2, 0);
            @(negedge clk);
            if (bus_b.clr_busy) cnt++;
            else break;
        end
        check_output("clear_len_B", 64'(cnt), 64'd16);
        check_output("B_post_clear", 64'(bus_b.rg_rd_data), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
